fifo_decoder: RTL and testbench
===============================

Name: fifo_decoder

Overview:
- Fixed-depth, stallable delay FIFO: each accepted DIN word re-emerges on DOUT exactly LENGTH accepted cycles later.
- Built as a LENGTH-entry ring buffer with a single wrapping pointer.
- The pointer is decoded into one-hot per-entry write enables and a read-select mux; this decode is the "decoder" part of the block.
- Sits in a datapath as an elastic-free delay line that freezes under back-pressure (STALL) or when disabled (EN low).

Parameters:
- DW, 4, data word width in bits (>=1).
- LENGTH, 4, number of storage entries, which is also the delay in accepted cycles (>=2; need not be a power of two).

Ports:
- CLK  input  1  rising-edge clock.
- RSTN  input  1  asynchronous active-low reset.
- EN  input  1  block enable; 0 freezes all state.
- STALL  input  1  back-pressure; 1 freezes all state.
- DIN  input  DW  data word written on an accepted cycle.
- DOUT  output  DW  registered oldest word, updated on accepted cycles only.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (RSTN=0, asynchronous, no clock needed):
  - All LENGTH entries cleared to 0.
  - Pointer set to 0.
  - DOUT set to 0.
  - State holds while RSTN=0; normal operation resumes on the first rising edge after release.
- Accept condition: adv = EN & ~STALL, sampled at the rising edge of CLK.
- On a rising edge with adv=1:
  - DOUT <= mem[ptr], i.e. the value before this edge's write.
  - mem[ptr] <= DIN.
  - ptr <= (ptr == LENGTH-1) ? 0 : ptr+1. Wrap is explicit; no reliance on power-of-two rollover.
- On a rising edge with adv=0: mem, ptr and DOUT all hold. DIN is ignored. The block is lossless across any stall length.
- Pointer width: $clog2(LENGTH).
- Write path: ptr decoded to a LENGTH-bit one-hot enable vector; only the selected entry loads.
- Read path: LENGTH:1 mux selected by ptr, feeding the DOUT register.
- Latency rule:
  - Number the accepted edges n = 1, 2, ...
  - After edge n, DOUT = DIN accepted at edge n-LENGTH.
  - DOUT = 0 for n <= LENGTH (reset contents flushing out).
- No full/empty flags: the buffer is always "full" of LENGTH words (reset zeros count as words). Steady-state throughput is one word in and one word out per accepted edge.
- EN and STALL are equivalent freeze sources; EN=0 with STALL=0 also holds.
- Reset mid-stream discards all stored words. The next LENGTH accepted edges produce DOUT=0.
- X on DIN during non-accepted cycles must not propagate into state.

Test Plan:
1. Reset check (DW=4, LENGTH=4): RSTN=0, EN=0, STALL=1 -> DOUT=0; pulse RSTN low asynchronously mid-cycle -> DOUT=0 immediately, without waiting for a clock edge.
2. Fill/latency: RSTN=1, EN=1, STALL=0, DIN = 3,2,5,1,4,7,0,6 on consecutive edges -> DOUT after each edge = 0,0,0,0,3,2,5,1.
3. Stall hold: after accepting 3, hold STALL=1 for 1-5 random cycles with DIN changing -> DOUT and contents frozen, changing DIN not captured. Resume with 2,5,1,4 -> DOUT = 0,0,0,3 on those edges (3 emerges on the 4th accepted edge after it).
4. Mixed stream: 3, stall, 2,5,1,4,7,0, stall, 6,2, stall, 1, then STALL=1 -> DOUT over accepted edges = 0,0,0,0,3,2,5,1,4,7. The final DOUT=7 then holds for 1000 time units of stall.
5. EN gating: EN=0, STALL=0 for 3 cycles mid-stream with DIN=4'hF -> no state change, 4'hF never appears on DOUT.
6. Wrap/non-power-of-two: LENGTH=3, stream 1..9 -> DOUT = 0,0,0,1,2,3,4,5,6; pointer cycles 0,1,2,0 with no stale reads.

Source files
------------

// File: rtl/fifo_decoder.sv
// fifo_decoder: fixed-depth delay line built as a ring buffer.
// Each accepted input word appears on DOUT exactly LENGTH accepted cycles later.
// A single wrapping pointer is decoded into one-hot write enables and a read mux.
// EN low or STALL high freezes every piece of state, so no words are lost across a stall.
module fifo_decoder #(
    parameter int DW     = 4,
    parameter int LENGTH = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          EN,
    input  logic          STALL,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT
);

    localparam int PW = $clog2(LENGTH);

    logic [DW-1:0]     r_mem [LENGTH];
    logic [PW-1:0]     r_ptr;
    logic [DW-1:0]     r_dout;

    logic              w_adv;
    logic [LENGTH-1:0] w_wrEn;
    logic [DW-1:0]     w_rdData;
    logic [PW-1:0]     w_ptrNext;

    assign w_adv = EN & ~STALL;

    // The pointer wraps explicitly at LENGTH-1, so LENGTH need not be a power of two.
    assign w_ptrNext = (r_ptr == PW'(LENGTH - 1)) ? '0 : r_ptr + PW'(1);

    // Decode the pointer into a one-hot enable; only the addressed entry may load.
    always_comb begin
        w_wrEn = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (r_ptr == PW'(i)) begin
                w_wrEn[i] = w_adv;
            end
        end
    end

    // Read mux: the addressed entry is the oldest word, about to be overwritten.
    always_comb begin
        w_rdData = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (r_ptr == PW'(i)) begin
                w_rdData = r_mem[i];
            end
        end
    end

    // Storage entries: cleared on reset, loaded only when selected on an accepted edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < LENGTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LENGTH; i++) begin
                if (w_wrEn[i]) begin
                    r_mem[i] <= DIN;
                end
            end
        end
    end

    // Pointer and output register advance together on accepted edges only.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ptr  <= '0;
            r_dout <= '0;
        end else if (w_adv) begin
            r_ptr  <= w_ptrNext;
            r_dout <= w_rdData;
        end
    end

    assign DOUT = r_dout;

endmodule

// File: tb/tb_fifo_decoder.sv
// Directed testbench for fifo_decoder: a LENGTH=4 instance for the main scenarios
// and a LENGTH=3 instance for the non-power-of-two wrap case.
module tb_fifo_decoder;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       stall;
    logic [3:0] din;
    logic [3:0] dout;

    logic       rstn3;
    logic       en3;
    logic       stall3;
    logic [3:0] din3;
    logic [3:0] dout3;

    int passCount;
    int checkCount;

    fifo_decoder #(.DW(4), .LENGTH(4)) dut (
        .CLK   (clk),
        .RSTN  (rstn),
        .EN    (en),
        .STALL (stall),
        .DIN   (din),
        .DOUT  (dout)
    );

    fifo_decoder #(.DW(4), .LENGTH(3)) dut3 (
        .CLK   (clk),
        .RSTN  (rstn3),
        .EN    (en3),
        .STALL (stall3),
        .DIN   (din3),
        .DOUT  (dout3)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs on the falling edge, take one rising edge, return at the next falling edge.
    task automatic applyStimulus(input logic e, input logic s, input logic [3:0] d);
        en    = e;
        stall = s;
        din   = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold the LENGTH=4 instance in reset for two cycles, then release on a falling edge.
    task automatic doReset;
        rstn  = 1'b0;
        en    = 1'b0;
        stall = 1'b1;
        din   = 4'h0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        doReset();
        checkCount++;
        if (dout !== 4'h0) $display("[TB] FAIL reset_idle: got %0h expected 0", dout);
        else passCount++;
        // Load a nonzero word so the asynchronous clear is observable.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 4'h9);
        checkCount++;
        if (dout !== 4'h9) $display("[TB] FAIL reset_preload: got %0h expected 9", dout);
        else passCount++;
        // Assert reset mid-cycle, well away from any rising edge.
        #2;
        rstn = 1'b0;
        #1;
        checkCount++;
        if (dout !== 4'h0) $display("[TB] FAIL reset_async: got %0h expected 0", dout);
        else passCount++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_fill;
        logic [3:0] dins [8];
        logic [3:0] exps [8];
        dins = '{4'd3, 4'd2, 4'd5, 4'd1, 4'd4, 4'd7, 4'd0, 4'd6};
        exps = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd2, 4'd5, 4'd1};
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, dins[i]);
            checkCount++;
            if (dout !== exps[i]) $display("[TB] FAIL fill_%0d: got %0h expected %0h", i, dout, exps[i]);
            else passCount++;
        end
    endtask

    task automatic test_stall;
        logic [3:0] dins [7];
        logic [3:0] exps [7];
        int         n;
        dins = '{4'd2, 4'd5, 4'd1, 4'd4, 4'd7, 4'd0, 4'd6};
        exps = '{4'd0, 4'd0, 4'd0, 4'd3, 4'd2, 4'd5, 4'd1};
        doReset();
        applyStimulus(1'b1, 1'b0, 4'd3);
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, 4'($urandom));
            checkCount++;
            if (dout !== 4'h0) $display("[TB] FAIL stall_hold_%0d: got %0h expected 0", i, dout);
            else passCount++;
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, dins[i]);
            checkCount++;
            if (dout !== exps[i]) $display("[TB] FAIL stall_resume_%0d: got %0h expected %0h", i, dout, exps[i]);
            else passCount++;
        end
    endtask

    task automatic test_mixed;
        logic       stl  [13];
        logic [3:0] dins [13];
        logic [3:0] exps [10];
        logic [3:0] lastExp;
        int         k;
        stl  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        dins = '{4'd3, 4'hA, 4'd2, 4'd5, 4'd1, 4'd4, 4'd7, 4'd0, 4'hB, 4'd6, 4'd2, 4'hC, 4'd1};
        exps = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd2, 4'd5, 4'd1, 4'd4, 4'd7};
        lastExp = 4'd0;
        k = 0;
        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, stl[i], dins[i]);
            if (!stl[i]) begin
                lastExp = exps[k];
                k++;
            end
            checkCount++;
            if (dout !== lastExp) $display("[TB] FAIL mixed_%0d: got %0h expected %0h", i, dout, lastExp);
            else passCount++;
        end
        stall = 1'b1;
        din   = 4'hE;
        #1000;
        checkCount++;
        if (dout !== 4'd7) $display("[TB] FAIL mixed_long_stall: got %0h expected 7", dout);
        else passCount++;
    endtask

    task automatic test_en_gating;
        logic [3:0] exps [5];
        exps = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        doReset();
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 4'(i));
        checkCount++;
        if (dout !== 4'd1) $display("[TB] FAIL en_pre: got %0h expected 1", dout);
        else passCount++;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'hF);
            checkCount++;
            if (dout !== 4'd1) $display("[TB] FAIL en_hold_%0d: got %0h expected 1", i, dout);
            else passCount++;
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(6 + i));
            checkCount++;
            if (dout !== exps[i]) $display("[TB] FAIL en_resume_%0d: got %0h expected %0h", i, dout, exps[i]);
            else passCount++;
        end
    endtask

    task automatic test_wrap;
        logic [3:0] exps [9];
        exps = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        rstn3  = 1'b0;
        en3    = 1'b0;
        stall3 = 1'b0;
        din3   = 4'h0;
        repeat (2) @(negedge clk);
        checkCount++;
        if (dout3 !== 4'h0) $display("[TB] FAIL wrap_reset: got %0h expected 0", dout3);
        else passCount++;
        rstn3 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            en3  = 1'b1;
            din3 = 4'(i + 1);
            @(posedge clk);
            @(negedge clk);
            checkCount++;
            if (dout3 !== exps[i]) $display("[TB] FAIL wrap_%0d: got %0h expected %0h", i, dout3, exps[i]);
            else passCount++;
        end
        en3 = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        passCount  = 0;
        checkCount = 0;
        rstn   = 1'b0;
        en     = 1'b0;
        stall  = 1'b1;
        din    = 4'h0;
        rstn3  = 1'b0;
        en3    = 1'b0;
        stall3 = 1'b0;
        din3   = 4'h0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_stall();
        test_mixed();
        test_en_gating();
        test_wrap();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
